// File: rtl/flag_stack.sv
// flag_stack: LIFO context save/restore for the 6-bit ALU FLAGS word, plus a
// registered branch-condition evaluator against the live FLAGS word.
// Optional macro FLAG_STACK_OVF_TRAP_EN: when defined, o_err is a sticky
// overflow/underflow indicator cleared only by i_rst; otherwise o_err is 0.
module flag_stack #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [5:0]                   i_flags_in,
   input  logic                         i_push,
   input  logic                         i_pop,
   output logic [5:0]                   o_flags_out,
   output logic                         o_restore_valid,
   input  logic [3:0]                   i_cond,
   input  logic                         i_cond_valid,
   output logic                         o_cond_true,
   output logic                         o_cond_done,
   output logic [$clog2(DEPTH+1)-1:0]   o_depth,
   output logic                         o_empty,
   output logic                         o_full,
   output logic                         o_err
);

   localparam int unsigned DW = $clog2(DEPTH + 1);
   localparam int unsigned IW = $clog2(DEPTH);

   logic [5:0]    r_mem [DEPTH];
   logic [DW-1:0] r_depth;
   logic [5:0]    r_flags_out;
   logic          r_restore_valid;
   logic          r_cond_true;
   logic          r_cond_done;

   logic          w_empty;
   logic          w_full;
   logic          w_swap;
   logic          w_push_eff;
   logic          w_pop_eff;
   logic          w_ovf;
   logic          w_udf;
   logic [IW-1:0] w_wr_idx;
   logic [IW-1:0] w_top_idx;
   logic          w_cond_hit;

   assign w_empty    = (r_depth == '0);
   assign w_full     = (r_depth == DW'(DEPTH));
   // Push+pop on a non-empty stack replaces the top in place.
   assign w_swap     = i_push && i_pop && !w_empty;
   // Push+pop on an empty stack degrades to a plain push.
   assign w_push_eff = i_push && !w_swap && !w_full;
   assign w_pop_eff  = i_pop && !i_push && !w_empty;
   assign w_ovf      = i_push && !i_pop && w_full;
   assign w_udf      = i_pop && w_empty;
   assign w_wr_idx   = IW'(r_depth);
   assign w_top_idx  = IW'(r_depth - 1'b1);

   // Storage array: written on effective push or swap; contents not reset.
   always_ff @(posedge i_clk) begin
      if (w_swap) begin
         r_mem[w_top_idx] <= i_flags_in;
      end else if (w_push_eff) begin
         r_mem[w_wr_idx] <= i_flags_in;
      end
   end

   // Depth pointer and restore output with its single-cycle qualifier.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_depth         <= '0;
         r_flags_out     <= 6'b000001;
         r_restore_valid <= 1'b0;
      end else begin
         r_restore_valid <= w_swap || w_pop_eff;
         if (w_swap || w_pop_eff) begin
            r_flags_out <= r_mem[w_top_idx];
         end
         if (w_push_eff) begin
            r_depth <= r_depth + 1'b1;
         end else if (w_pop_eff) begin
            r_depth <= r_depth - 1'b1;
         end
      end
   end

   // Branch condition decode against the live flags.
   always_comb begin
      w_cond_hit = 1'b0;
      case (i_cond)
         4'd0:    w_cond_hit = 1'b1;
         4'd1:    w_cond_hit = i_flags_in[1];
         4'd2:    w_cond_hit = !i_flags_in[1];
         4'd3:    w_cond_hit = i_flags_in[2];
         4'd4:    w_cond_hit = !i_flags_in[2];
         4'd5:    w_cond_hit = i_flags_in[3];
         4'd6:    w_cond_hit = !i_flags_in[3];
         4'd7:    w_cond_hit = i_flags_in[4];
         4'd8:    w_cond_hit = !i_flags_in[4];
         4'd9:    w_cond_hit = i_flags_in[5];
         4'd10:   w_cond_hit = !i_flags_in[5];
         4'd11:   w_cond_hit = i_flags_in[2] || i_flags_in[1];
         4'd12:   w_cond_hit = !i_flags_in[2] && !i_flags_in[1];
         4'd13:   w_cond_hit = i_flags_in[5] || i_flags_in[1];
         4'd14:   w_cond_hit = !i_flags_in[5] && !i_flags_in[1];
         default: w_cond_hit = 1'b0;
      endcase
   end

   // Registered condition result; holds between evaluations.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cond_true <= 1'b0;
         r_cond_done <= 1'b0;
      end else begin
         r_cond_done <= i_cond_valid;
         if (i_cond_valid) begin
            r_cond_true <= w_cond_hit;
         end
      end
   end

`ifdef FLAG_STACK_OVF_TRAP_EN
   logic r_err;

   // Sticky trap on any dropped push or pop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if (w_ovf || w_udf) begin
         r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`else
   logic w_unused_evt;
   assign w_unused_evt = w_ovf ^ w_udf;
   assign o_err        = 1'b0;
`endif

   assign o_flags_out     = r_flags_out;
   assign o_restore_valid = r_restore_valid;
   assign o_cond_true     = r_cond_true;
   assign o_cond_done     = r_cond_done;
   assign o_depth         = r_depth;
   assign o_empty         = w_empty;
   assign o_full          = w_full;

endmodule

// File: tb/tb_flag_stack.sv
// Directed bench for flag_stack (DEPTH=4); err expectations follow
// whether FLAG_STACK_OVF_TRAP_EN is defined for the build.
module tb_flag_stack;

   localparam int unsigned DEPTH = 4;
`ifdef FLAG_STACK_OVF_TRAP_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] flags_in = '0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [3:0] cond = '0;
   logic       cond_valid = 1'b0;
   logic [5:0] flags_out;
   logic       restore_valid;
   logic       cond_true;
   logic       cond_done;
   logic [2:0] depth;
   logic       empty;
   logic       full;
   logic       err;

   int n_checks = 0;
   int n_fail   = 0;

   flag_stack #(.DEPTH(DEPTH)) u_dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_flags_in      (flags_in),
      .i_push          (push),
      .i_pop           (pop),
      .o_flags_out     (flags_out),
      .o_restore_valid (restore_valid),
      .i_cond          (cond),
      .i_cond_valid    (cond_valid),
      .o_cond_true     (cond_true),
      .o_cond_done     (cond_done),
      .o_depth         (depth),
      .o_empty         (empty),
      .o_full          (full),
      .o_err           (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; push = 1'b0; pop = 1'b0; cond_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic push_one(input logic [5:0] v);
      flags_in = v; push = 1'b1;
      step();
      push = 1'b0;
   endtask

   task automatic cond_eval(input string tag, input logic [5:0] f, input logic [3:0] c,
                            input logic exp);
      flags_in = f; cond = c; cond_valid = 1'b1;
      step();
      check({tag, "_true"}, 8'(cond_true), 8'(exp));
      check({tag, "_done"}, 8'(cond_done), 8'd1);
   endtask

   initial begin
      logic [5:0] exp_pop [4];

      // Reset state
      do_reset();
      check("rst_depth", 8'(depth), 8'd0);
      check("rst_empty", 8'(empty), 8'd1);
      check("rst_full", 8'(full), 8'd0);
      check("rst_flags_out", 8'(flags_out), 8'h01);
      check("rst_rv", 8'(restore_valid), 8'd0);
      check("rst_cond_true", 8'(cond_true), 8'd0);
      check("rst_cond_done", 8'(cond_done), 8'd0);
      check("rst_err", 8'(err), 8'd0);

      // Three pushes, three back-to-back pops in LIFO order
      push_one(6'h05);
      push_one(6'h0B);
      push_one(6'h31);
      check("lifo_depth3", 8'(depth), 8'd3);
      pop = 1'b1;
      step();
      check("lifo_pop1", 8'(flags_out), 8'h31);
      check("lifo_rv1", 8'(restore_valid), 8'd1);
      step();
      check("lifo_pop2", 8'(flags_out), 8'h0B);
      check("lifo_rv2", 8'(restore_valid), 8'd1);
      step();
      check("lifo_pop3", 8'(flags_out), 8'h05);
      check("lifo_rv3", 8'(restore_valid), 8'd1);
      pop = 1'b0;
      step();
      check("lifo_rv_end", 8'(restore_valid), 8'd0);
      check("lifo_empty", 8'(empty), 8'd1);

      // Overflow: fifth push dropped
      do_reset();
      for (int i = 1; i <= 5; i++) push_one(6'(i));
      check("ovf_full", 8'(full), 8'd1);
      check("ovf_depth", 8'(depth), 8'd4);
      check("ovf_err", 8'(err), 8'(EXP_ERR));
      exp_pop[0] = 6'h04; exp_pop[1] = 6'h03; exp_pop[2] = 6'h02; exp_pop[3] = 6'h01;
      pop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("ovf_pop", 8'(flags_out), 8'(exp_pop[i]));
         check("ovf_pop_rv", 8'(restore_valid), 8'd1);
      end
      pop = 1'b0;
      check("ovf_empty", 8'(empty), 8'd1);

      // Underflow on a freshly reset stack
      do_reset();
      pop = 1'b1;
      step();
      pop = 1'b0;
      check("udf_rv", 8'(restore_valid), 8'd0);
      check("udf_flags_out", 8'(flags_out), 8'h01);
      check("udf_depth", 8'(depth), 8'd0);
      check("udf_err", 8'(err), 8'(EXP_ERR));

      // Swap: push+pop on non-empty stack
      do_reset();
      push_one(6'h03);
      push_one(6'h07);
      flags_in = 6'h21; push = 1'b1; pop = 1'b1;
      step();
      push = 1'b0;
      check("swap_flags_out", 8'(flags_out), 8'h07);
      check("swap_rv", 8'(restore_valid), 8'd1);
      check("swap_depth", 8'(depth), 8'd2);
      step();
      check("swap_next_pop", 8'(flags_out), 8'h21);
      check("swap_next_depth", 8'(depth), 8'd1);
      step();
      pop = 1'b0;
      check("swap_last_pop", 8'(flags_out), 8'h03);
      check("swap_no_err", 8'(err), 8'd0);

      // Push+pop on empty: acts as push, no restore, underflow event
      flags_in = 6'h15; push = 1'b1; pop = 1'b1;
      step();
      push = 1'b0; pop = 1'b0;
      check("pp_empty_rv", 8'(restore_valid), 8'd0);
      check("pp_empty_depth", 8'(depth), 8'd1);
      check("pp_empty_flags_out", 8'(flags_out), 8'h03);
      check("pp_empty_err", 8'(err), 8'(EXP_ERR));
      pop = 1'b1;
      step();
      pop = 1'b0;
      check("pp_empty_pop", 8'(flags_out), 8'h15);

      // Condition evaluation
      do_reset();
      cond_eval("c1_z", 6'h07, 4'd1, 1'b1);
      cond_eval("c2_nz", 6'h07, 4'd2, 1'b0);
      cond_eval("c11_ule", 6'h07, 4'd11, 1'b1);
      cond_eval("c12_ugt", 6'h07, 4'd12, 1'b0);
      cond_eval("c3_c", 6'h07, 4'd3, 1'b1);
      cond_eval("c5_n", 6'h07, 4'd5, 1'b0);
      cond_eval("c13_sle", 6'h21, 4'd13, 1'b1);
      cond_eval("c14_sgt", 6'h21, 4'd14, 1'b0);
      cond_eval("c0_always", 6'h21, 4'd0, 1'b1);
      cond_eval("c15_never", 6'h21, 4'd15, 1'b0);
      cond_eval("c0_again", 6'h00, 4'd0, 1'b1);
      cond_valid = 1'b0; cond = 4'd15;
      step();
      check("cond_hold_true", 8'(cond_true), 8'd1);
      check("cond_hold_done", 8'(cond_done), 8'd0);

      // Reset mid-pop discards entries and pending pulse
      do_reset();
      push_one(6'h11);
      push_one(6'h22);
      pop = 1'b1;
      step();
      check("rstmid_pop", 8'(flags_out), 8'h22);
      rst = 1'b1;
      step();
      rst = 1'b0; pop = 1'b0;
      check("rstmid_depth", 8'(depth), 8'd0);
      check("rstmid_rv", 8'(restore_valid), 8'd0);
      check("rstmid_flags_out", 8'(flags_out), 8'h01);
      check("rstmid_err", 8'(err), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
